// File: rtl/ram_dp_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM: read-during-write
// mode codes, a byte-count helper and the byte-merge function used for the
// write-first bypass.
package ram_dp_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MAX_BYTES = 8;
    localparam int MAX_WIDTH = MAX_BYTES * 8;

    // Number of byte lanes in a word of the given width.
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    // Byte-wise merge: lanes with be set take new_word, the rest keep old_word.
    function automatic logic [MAX_WIDTH-1:0] merge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < MAX_BYTES; k++) begin
            res[k*8 +: 8] = be[k] ? new_word[k*8 +: 8] : old_word[k*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_dp_rd_pipe.sv
// Read-return staging for one RAM port: one register stage (latency 1) or
// two (latency 2). rdata only moves when a valid word passes through, so it
// holds the last returned value while rvalid is low.
module ram_dp_rd_pipe
    import ram_dp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic                  v1_r;
    logic [DATA_WIDTH-1:0] d1_r;

    // First stage: capture the word read from the array this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            d1_r <= '0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                d1_r <= in_data;
            end else begin
                d1_r <= d1_r;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_two_stage
            logic                  v2_r;
            logic [DATA_WIDTH-1:0] d2_r;

            // Second stage: extra output register for timing.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2_r <= 1'b0;
                    d2_r <= '0;
                end else begin
                    v2_r <= v1_r;
                    if (v1_r) begin
                        d2_r <= d1_r;
                    end else begin
                        d2_r <= d2_r;
                    end
                end
            end

            assign rvalid = v2_r;
            assign rdata  = d2_r;
        end else begin : g_one_stage
            assign rvalid = v1_r;
            assign rdata  = d1_r;
        end
    endgenerate

endmodule

// File: rtl/ram_dp_sync_be.sv
// True dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register, and registered
// collision / out-of-range pulses. The array itself is never reset.
module ram_dp_sync_be
    import ram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs_0,
    input  logic                    we_0,
    input  logic [DATA_WIDTH/8-1:0] be_0,
    input  logic [ADDR_WIDTH-1:0]   addr_0,
    input  logic [DATA_WIDTH-1:0]   wdata_0,
    output logic [DATA_WIDTH-1:0]   rdata_0,
    output logic                    rvalid_0,
    input  logic                    cs_1,
    input  logic                    we_1,
    input  logic [DATA_WIDTH/8-1:0] be_1,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    output logic [DATA_WIDTH-1:0]   rdata_1,
    output logic                    rvalid_1,
    output logic                    coll,
    output logic                    oor_0,
    output logic                    oor_1
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // run_r stays low for the first edge after reset release so that an
    // access presented on that edge is ignored.
    logic run_r;
    logic coll_r;
    logic oor_0_r;
    logic oor_1_r;

    logic                  in_rng_0_s;
    logic                  in_rng_1_s;
    logic                  wr_0_s;
    logic                  wr_1_s;
    logic                  rd_0_s;
    logic                  rd_1_s;
    logic                  same_addr_s;
    logic [DATA_WIDTH-1:0] old_0_s;
    logic [DATA_WIDTH-1:0] old_1_s;
    logic [DATA_WIDTH-1:0] merged_0_s;
    logic [DATA_WIDTH-1:0] merged_1_s;
    logic [DATA_WIDTH-1:0] rd_data_0_s;
    logic [DATA_WIDTH-1:0] rd_data_1_s;

    assign in_rng_0_s  = ({1'b0, addr_0} < DEPTH_C);
    assign in_rng_1_s  = ({1'b0, addr_1} < DEPTH_C);
    assign wr_0_s      = run_r & cs_0 & we_0 & in_rng_0_s;
    assign wr_1_s      = run_r & cs_1 & we_1 & in_rng_1_s;
    assign rd_0_s      = run_r & cs_0 & ~we_0;
    assign rd_1_s      = run_r & cs_1 & ~we_1;
    assign same_addr_s = (addr_0 == addr_1);

    // Fetch the stored words; out-of-range reads return zero.
    always_comb begin
        old_0_s = '0;
        old_1_s = '0;
        if (in_rng_0_s) begin
            old_0_s = mem_r[addr_0];
        end else begin
            old_0_s = '0;
        end
        if (in_rng_1_s) begin
            old_1_s = mem_r[addr_1];
        end else begin
            old_1_s = '0;
        end
    end

    // Word a reader would see if the other port's write landed first.
    assign merged_0_s = DATA_WIDTH'(merge(MAX_WIDTH'(old_0_s), MAX_WIDTH'(wdata_1), MAX_BYTES'(be_1)));
    assign merged_1_s = DATA_WIDTH'(merge(MAX_WIDTH'(old_1_s), MAX_WIDTH'(wdata_0), MAX_BYTES'(be_0)));

    // Bypass mux: in write-first mode a read hitting the other port's write
    // returns the merged word, otherwise the pre-write contents.
    always_comb begin
        rd_data_0_s = old_0_s;
        rd_data_1_s = old_1_s;
        if ((READ_MODE == WRITE_FIRST) && wr_1_s && same_addr_s) begin
            rd_data_0_s = merged_0_s;
        end else begin
            rd_data_0_s = old_0_s;
        end
        if ((READ_MODE == WRITE_FIRST) && wr_0_s && same_addr_s) begin
            rd_data_1_s = merged_1_s;
        end else begin
            rd_data_1_s = old_1_s;
        end
    end

    // Array write with arbitration: port 0 owns every byte it enables on a
    // shared address; port 1 still lands the bytes port 0 leaves alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < BYTES; k++) begin
            if (wr_1_s && be_1[k] && !(wr_0_s && be_0[k] && same_addr_s)) begin
                mem_r[addr_1][k*8 +: 8] <= wdata_1[k*8 +: 8];
            end
            if (wr_0_s && be_0[k]) begin
                mem_r[addr_0][k*8 +: 8] <= wdata_0[k*8 +: 8];
            end
        end
    end

    // Run enable and one-cycle status pulses, aligned with latency-1 data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r   <= 1'b0;
            coll_r  <= 1'b0;
            oor_0_r <= 1'b0;
            oor_1_r <= 1'b0;
        end else begin
            run_r   <= 1'b1;
            coll_r  <= wr_0_s & wr_1_s & same_addr_s;
            oor_0_r <= run_r & cs_0 & ~in_rng_0_s;
            oor_1_r <= run_r & cs_1 & ~in_rng_1_s;
        end
    end

    assign coll  = coll_r;
    assign oor_0 = oor_0_r;
    assign oor_1 = oor_1_r;

    ram_dp_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe_0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_0_s),
        .in_data  (rd_data_0_s),
        .rvalid   (rvalid_0),
        .rdata    (rdata_0)
    );

    ram_dp_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_rd_pipe_1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd_1_s),
        .in_data  (rd_data_1_s),
        .rvalid   (rvalid_1),
        .rdata    (rdata_1)
    );

endmodule
